// File: rtl/ryuki_datatypes.sv
// Shared datatypes for the ryuki core debug path: trace records and trace-buffer entries.
package ryuki_datatypes;

  localparam int unsigned TRACE_SEQ_WIDTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_output;

  typedef struct packed {
    trace_output                rec;
    logic [TRACE_SEQ_WIDTH-1:0] seq;
  } trace_buffer_entry;

  typedef enum logic [1:0] {
    StEmpty  = 2'd0,
    StActive = 2'd1,
    StFull   = 2'd2
  } trace_buffer_state_e;

endpackage

// File: rtl/trace_buffer_mem.sv
// Register-array storage for trace_buffer: synchronous write, asynchronous read.
module trace_buffer_mem
  import ryuki_datatypes::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = trace_buffer_entry
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  entry_t                   i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output entry_t                   o_rdata
);

  // Contents are deliberately not reset; the top masks outputs while empty.
  entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_buffer.sv
// Elastic, never-stalling FIFO for trace records with sequence tags and drop accounting.
// Optional feature macro: TRACE_BUFFER_DROP_COUNT_EN enables overflow/drop_count.
module trace_buffer
  import ryuki_datatypes::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SEQ_WIDTH  = TRACE_SEQ_WIDTH,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_data_ready,
  input  trace_output              trace_data_i,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output trace_output              out_data,
  output logic [SEQ_WIDTH-1:0]     out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [DROP_WIDTH-1:0]    drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] LvlOne  = LvlW'(1);

  typedef struct packed {
    trace_output          rec;
    logic [SEQ_WIDTH-1:0] seq;
  } entry_t;

  trace_buffer_state_e r_state, w_state_next;

  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [LvlW-1:0]      r_level;
  logic [LvlW-1:0]      w_level_next;
  logic [SEQ_WIDTH-1:0] r_seq_ctr;
  logic                 w_pop;
  logic                 w_push;
  entry_t               w_wr_entry;
  entry_t               w_rd_entry;

  assign w_pop  = out_valid && out_ready && !flush;
  // A full buffer still accepts a record when the head leaves in the same cycle.
  assign w_push = trace_data_ready && !flush && (!full || w_pop);

  assign w_wr_entry.rec = trace_data_i;
  assign w_wr_entry.seq = r_seq_ctr;

  trace_buffer_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LvlOne;
      2'b01:   w_level_next = r_level - LvlOne;
      default: w_level_next = r_level;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = StEmpty;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_push) w_state_next = StActive;
        end
        StActive: begin
          if (w_push && !w_pop && (r_level == LvlFull - LvlOne)) begin
            w_state_next = StFull;
          end else if (w_pop && !w_push && (r_level == LvlOne)) begin
            w_state_next = StEmpty;
          end
        end
        StFull: begin
          if (w_pop && !w_push) w_state_next = StActive;
        end
        default: w_state_next = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StEmpty;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_seq_ctr <= '0;
    end else begin
      r_state <= w_state_next;
      // Every strobe consumes a tag, so gaps in out_seq expose lost records.
      if (trace_data_ready) begin
        r_seq_ctr <= r_seq_ctr + SEQ_WIDTH'(1);
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_level <= w_level_next;
      end
    end
  end

`ifdef TRACE_BUFFER_DROP_COUNT_EN
  logic                  w_drop;
  logic                  r_overflow;
  logic [DROP_WIDTH-1:0] r_drop_count;

  assign w_drop = trace_data_ready && !flush && full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (flush) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + DROP_WIDTH'(1);
      end
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
`else
  assign overflow   = 1'b0;
  assign drop_count = '0;
`endif

  assign out_valid = (r_state != StEmpty);
  assign empty     = (r_state == StEmpty);
  assign full      = (r_state == StFull);
  assign level     = r_level;
  assign out_data  = out_valid ? w_rd_entry.rec : '0;
  assign out_seq   = out_valid ? w_rd_entry.seq : '0;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (DEPTH=16), both drop-counter builds.
module tb_trace_buffer;
  import ryuki_datatypes::*;

  localparam int unsigned Depth = 16;
`ifdef TRACE_BUFFER_DROP_COUNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_data_ready;
  trace_output trace_data_i;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  trace_output out_data;
  logic [15:0] out_seq;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trace_buffer #(
    .DEPTH      (Depth),
    .SEQ_WIDTH  (16),
    .DROP_WIDTH (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .trace_data_ready (trace_data_ready),
    .trace_data_i     (trace_data_i),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_seq          (out_seq),
    .level            (level),
    .full             (full),
    .empty            (empty),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic trace_output rec(input int i);
    trace_output r;
    r.pc    = 32'h1000_0000 + 32'(i) * 32'd4;
    r.instr = 32'hA500_0000 ^ 32'(i * 7);
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trace_data_ready = 1'b0;
    out_ready        = 1'b0;
    flush            = 1'b0;
    trace_data_i     = '0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic push_n(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      trace_data_ready = 1'b1;
      trace_data_i     = rec(first + i);
      tick();
    end
    trace_data_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    trace_data_ready = 1'b0;
    out_ready        = 1'b0;
    flush            = 1'b0;
    trace_data_i     = '0;
    rst              = 1'b1;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drops", 64'(drop_count), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_seq", 64'(out_seq), 64'd0);
    rst = 1'b0;
    tick();

    // Single record, first-word-fall-through
    push_n(100, 1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'(rec(100)));
    check("single_seq", 64'(out_seq), 64'd0);
    check("single_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_empty", 64'(empty), 64'd1);
    check("single_level0", 64'(level), 64'd0);

    // Fill with stalled sink, then overflow by 3
    do_reset();
    push_n(0, 16);
    check("fill_full", 64'(full), 64'd1);
    check("fill_level", 64'(level), 64'd16);
    check("fill_head_stable", 64'(out_data), 64'(rec(0)));
    push_n(16, 3);
    check("drop_count", 64'(drop_count), DropEn ? 64'd3 : 64'd0);
    check("drop_ovf", 64'(overflow), DropEn ? 64'd1 : 64'd0);
    check("drop_level", 64'(level), 64'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_seq%0d", i), 64'(out_seq), 64'(i));
      check($sformatf("drain_data%0d", i), 64'(out_data), 64'(rec(i)));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);
    push_n(50, 1);
    check("post_drop_seq", 64'(out_seq), 64'd19);

    // Push+pop while full
    do_reset();
    push_n(0, 16);
    trace_data_ready = 1'b1;
    trace_data_i     = rec(77);
    out_ready        = 1'b1;
    tick();
    trace_data_ready = 1'b0;
    out_ready        = 1'b0;
    check("pp_level", 64'(level), 64'd16);
    check("pp_full", 64'(full), 64'd1);
    check("pp_drops", 64'(drop_count), 64'd0);
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_head_seq", 64'(out_seq), 64'd1);
    check("pp_head_data", 64'(out_data), 64'(rec(1)));

    // Wrap-around streaming at one record per cycle
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      trace_data_ready = 1'b1;
      trace_data_i     = rec(200 + k);
      tick();
      check($sformatf("wrap_seq%0d", k), 64'(out_seq), 64'(k));
      check($sformatf("wrap_data%0d", k), 64'(out_data), 64'(rec(200 + k)));
      check($sformatf("wrap_level%0d", k), 64'(level), 64'd1);
    end
    trace_data_ready = 1'b0;
    tick();
    out_ready = 1'b0;
    check("wrap_empty", 64'(empty), 64'd1);

    // Flush with 5 stored records and 2 drops; the coincident strobe is discarded
    do_reset();
    push_n(0, 18);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    out_ready = 1'b0;
    check("pre_flush_level", 64'(level), 64'd5);
    check("pre_flush_drops", 64'(drop_count), DropEn ? 64'd2 : 64'd0);
    flush            = 1'b1;
    trace_data_ready = 1'b1;
    trace_data_i     = rec(300);
    tick();
    flush            = 1'b0;
    trace_data_ready = 1'b0;
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_level", 64'(level), 64'd0);
    check("flush_drops", 64'(drop_count), 64'd0);
    check("flush_ovf", 64'(overflow), 64'd0);
    push_n(301, 1);
    check("flush_next_seq", 64'(out_seq), 64'd19);
    check("flush_next_data", 64'(out_data), 64'(rec(301)));
    check("flush_next_level", 64'(level), 64'd1);

    // Asynchronous reset between edges
    do_reset();
    push_n(400, 7);
    check("mid_level", 64'(level), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    check("arst_level", 64'(level), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_seq", 64'(out_seq), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    #1;
    rst = 1'b0;
    push_n(500, 1);
    check("arst_first_seq", 64'(out_seq), 64'd0);
    check("arst_first_data", 64'(out_data), 64'(rec(500)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
